// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_seq
// Purpose  : Multi-cycle WIDTH-bit adder that time-multiplexes one external
//            3-bit combinational adder slice. Operands arrive over a
//            valid/ready handshake and are walked through the slice 3 bits
//            per cycle, LSB chunk first, with the carry chained in a
//            register. The full sum and carry-out are returned over a
//            second valid/ready handshake.
//
// Ports    : clk, rst                 clock, synchronous active-high reset
//            in_valid/in_ready        operand handshake
//            in_a, in_b, in_cin       operands and LSB carry-in
//            out_valid/out_ready      result handshake
//            out_sum, out_cout        registered result
//            busy                     high while an operation is in flight
//            slice_a/b/cin            drive to the external 3-bit slice
//            slice_sum/cout           combinational return from the slice
//
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    // operand side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    // external slice
    output logic [2:0]       slice_a,
    output logic [2:0]       slice_b,
    output logic             slice_cin,
    input  logic [2:0]       slice_sum,
    input  logic             slice_cout
);

    // Number of slice passes and the width of the chunk index.
    localparam int N  = WIDTH / 3;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    // Result registers kept apart from r_sum so the last completed result
    // stays visible on out_sum/out_cout after r_sum is cleared at the next
    // accept.
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;

    logic [2:0]       w_chunk_a;
    logic [2:0]       w_chunk_b;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;
    logic             w_accept;

    // ------------------------------------------------------------------------
    // Chunk selection: pick the 3-bit operand chunk addressed by r_idx and
    // build the sum word with the current slice result merged into place.
    // An explicit compare loop keeps every slice a constant part-select.
    // ------------------------------------------------------------------------
    always_comb begin
        w_chunk_a  = 3'd0;
        w_chunk_b  = 3'd0;
        w_sum_next = r_sum;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
                w_chunk_a            = r_a[3*k +: 3];
                w_chunk_b            = r_b[3*k +: 3];
                w_sum_next[3*k +: 3] = slice_sum;
            end
        end
    end

    assign w_last = (r_idx == IW'(N - 1));

    // in_ready is masked by rst combinationally so no operand can be taken
    // on an edge where the block is being reset.
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Next-state and slice drive. The slice is only driven during RUN so the
    // shared slice sees quiet inputs whenever this block is not using it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        slice_a      = 3'd0;
        slice_b      = 3'd0;
        slice_cin    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                slice_a   = w_chunk_a;
                slice_b   = w_chunk_b;
                slice_cin = r_carry;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers. The operand registers only load in IDLE, so they
    // stay frozen for the whole operation regardless of in_a/in_b activity.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= slice_cout;
                    if (w_last) begin
                        // Final pass: publish the completed result so it is
                        // already stable when out_valid rises.
                        r_out_sum  <= w_sum_next;
                        r_out_cout <= slice_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------------
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_seq
// Purpose  : Self-checking bench for serial_adder_seq (WIDTH=12). Expected
//            results are queued when an operand set is accepted; a monitor
//            pops and compares whenever a result handshake occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;

    localparam int WIDTH = 12;
    localparam int N     = WIDTH / 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
    logic [2:0]       slice_a;
    logic [2:0]       slice_b;
    logic             slice_cin;
    logic [2:0]       slice_sum;
    logic             slice_cout;

    int               checks;
    int               errors;
    int               cyc;
    logic [WIDTH:0]   exp_q[$];

    serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .busy       (busy),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    // Behavioural 3-bit adder slice.
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {3'b000, slice_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one operand set and wait for it to be accepted. Returns just
    // after the accept edge with accept_cyc holding that edge's number.
    // in_valid is left high; the caller lowers it when appropriate.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input bit push, output int accept_cyc);
        bit got;
        got = 0;
        @(posedge clk); #1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        accept_cyc = cyc;
        if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
    endtask

    task automatic wait_valid();
        bit got;
        got = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int a0, a1;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [2:0]       exp_sa[4];

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        // Monitor: pops an expectation on every result handshake and keeps
        // an eye on the in_ready/busy exclusivity.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    chk("ready_while_busy", 32'(in_ready && busy), 32'd0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 32'({out_cout, out_sum}), 32'hFFFF_FFFF);
                        end else begin
                            chk("result", 32'({out_cout, out_sum}), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cout",  32'(out_cout),  32'd0);
        chk("rst_slice",     32'({slice_a, slice_b, slice_cin}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Full carry chain and latency.
        send(12'hFFF, 12'h001, 1'b0, 1, a0);
        in_valid = 1'b0;
        wait_valid();
        chk("latency", 32'(cyc - a0), 32'(N));
        chk("carry_chain_sum",  32'(out_sum),  32'h000);
        chk("carry_chain_cout", 32'(out_cout), 32'd1);
        wait_idle();

        // Mixed values; record slice_a over the RUN cycles.
        exp_sa[0] = 3'd3; exp_sa[1] = 3'd4; exp_sa[2] = 3'd6; exp_sa[3] = 3'd2;
        send(12'h5A3, 12'h2C4, 1'b1, 1, a0);
        in_valid = 1'b0;
        // Operands change after acceptance must not matter.
        in_a = 12'h000;
        in_b = 12'hFFF;
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            chk("slice_a_seq", 32'(slice_a), 32'(exp_sa[i]));
        end
        wait_valid();
        chk("mixed_sum",  32'(out_sum),  32'h868);
        chk("mixed_cout", 32'(out_cout), 32'd0);
        wait_idle();

        // Backpressure.
        send(12'h800, 12'h800, 1'b0, 1, a0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_sum",      32'(out_sum),   32'h000);
            chk("bp_cout",     32'(out_cout),  32'd1);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_released_valid", 32'(out_valid), 32'd0);
        chk("bp_released_ready", 32'(in_ready),  32'd1);

        // Back-to-back with in_valid held high.
        send(12'h123, 12'h456, 1'b0, 1, a0);
        send(12'hABC, 12'h544, 1'b1, 1, a1);
        in_valid = 1'b0;
        chk("b2b_spacing", 32'(a1 - a0), 32'(N + 2));
        wait_idle();

        // Reset during the second RUN cycle aborts the operation.
        send(12'h321, 12'h111, 1'b1, 0, a0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_slice",     32'({slice_a, slice_b, slice_cin}), 32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        send(12'h001, 12'h001, 1'b0, 1, a0);
        in_valid = 1'b0;
        wait_valid();
        chk("post_abort_sum",  32'(out_sum),  32'h002);
        chk("post_abort_cout", 32'(out_cout), 32'd0);
        wait_idle();

        // Random operands with random result stalls.
        for (int i = 0; i < 1000; i++) begin
            bit done;
            ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, 1, a0);
            in_valid = 1'b0;
            done = 0;
            for (int t = 0; t < 200; t++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (out_valid && out_ready) begin
                    done = 1;
                    break;
                end
            end
            if (!done) chk("rand_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
